// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the register-file writeback arbiter: width defaults,
// requester ids, pointer encoding and the writeback request record.
package regfile_wb_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_MEM = 1'b1
    } prio_e;

    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0] rd;
        logic [DATA_WIDTH_DEF-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: owns the priority pointer and produces the
// per-requester ready and one-hot grant.
module rr_arb2
    import regfile_wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] ready,
    output logic [1:0] grant
);

    prio_e      prio_q;
    prio_e      prio_d;
    logic [1:0] favoured;

    assign favoured[REQ_ALU] = (prio_q == PRIO_ALU);
    assign favoured[REQ_MEM] = (prio_q == PRIO_MEM);

    // A requester is ready when the other side is idle or it holds priority;
    // its own valid never feeds its ready.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign ready[gi] = rst_n && (!req[1-gi] || favoured[gi]);
        assign grant[gi] = req[gi] && ready[gi];
    end

    always_comb begin
        prio_d = prio_q;
        if (grant[REQ_ALU]) begin
            prio_d = PRIO_MEM;
        end else if (grant[REQ_MEM]) begin
            prio_d = PRIO_ALU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= PRIO_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port (ALU vs load).
// Optional macro REG0_ZERO_EN: granted writes to register 0 are suppressed.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,
    output logic                  RegWr,
    output logic [ADDR_WIDTH-1:0] Rw,
    output logic [DATA_WIDTH-1:0] busW
);

    logic [1:0]            req;
    logic [1:0]            ready;
    logic [1:0]            grant;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  regwr_q, regwr_d;
    logic [ADDR_WIDTH-1:0] rw_q,    rw_d;
    logic [DATA_WIDTH-1:0] busw_q,  busw_d;

    assign req[REQ_ALU] = alu_valid;
    assign req[REQ_MEM] = mem_valid;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .ready (ready),
        .grant (grant)
    );

    assign alu_ready = ready[REQ_ALU];
    assign mem_ready = ready[REQ_MEM];

    always_comb begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
        if (grant[REQ_MEM]) begin
            sel_rd   = mem_rd;
            sel_data = mem_data;
        end

        regwr_d = 1'b0;
        rw_d    = rw_q;
        busw_d  = busw_q;
        if (|grant) begin
            rw_d   = sel_rd;
            busw_d = sel_data;
`ifdef REG0_ZERO_EN
            // Register 0 is hardwired: the request is consumed but never written.
            regwr_d = (sel_rd != '0);
`else
            regwr_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwr_q <= 1'b0;
            rw_q    <= '0;
            busw_q  <= '0;
        end else begin
            regwr_q <= regwr_d;
            rw_q    <= rw_d;
            busw_q  <= busw_d;
        end
    end

    assign RegWr = regwr_q;
    assign Rw    = rw_q;
    assign busW  = busw_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scoreboard bench for regfile_wb_arbiter; honours REG0_ZERO_EN when
// defined so the same bench covers both builds.
module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;

    localparam int DW = DATA_WIDTH_DEF;
    localparam int AW = ADDR_WIDTH_DEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          alu_ready;
    logic          mem_valid = 1'b0;
    logic [AW-1:0] mem_rd = '0;
    logic [DW-1:0] mem_data = '0;
    logic          mem_ready;
    logic          RegWr;
    logic [AW-1:0] Rw;
    logic [DW-1:0] busW;

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .RegWr     (RegWr),
        .Rw        (Rw),
        .busW      (busW)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic    we;
        wb_req_t req;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp  = 0;
    int            n_fail = 0;
    logic          model_prio = 1'b0;
    logic [AW-1:0] last_rw    = '0;
    logic [DW-1:0] last_busw  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check readies, predict the write, then check
    // the output stage after the rising edge.
    task automatic step(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                        input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md);
        logic ea, em;
        exp_t e;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        #1;
        ea = !mv || (model_prio == 1'b0);
        em = !av || (model_prio == 1'b1);
        check("alu_ready", {63'd0, alu_ready}, {63'd0, ea});
        check("mem_ready", {63'd0, mem_ready}, {63'd0, em});
        e = '0;
        if (av && ea) begin
            e.we = 1'b1; e.req.rd = ard; e.req.data = ad; model_prio = 1'b1;
        end else if (mv && em) begin
            e.we = 1'b1; e.req.rd = mrd; e.req.data = md; model_prio = 1'b0;
        end
        if (e.we) begin
            last_rw   = e.req.rd;
            last_busw = e.req.data;
`ifdef REG0_ZERO_EN
            if (e.req.rd == '0) e.we = 1'b0;
`endif
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("RegWr", {63'd0, RegWr}, {63'd0, e.we});
        check("Rw", {59'd0, Rw}, {59'd0, last_rw});
        check("busW", {32'd0, busW}, {32'd0, last_busw});
        $display("step av=%0b mv=%0b -> RegWr=%0b Rw=%0d busW=%h", av, mv, RegWr, Rw, busW);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Asynchronous reset pulse between clock edges; valids stay asserted while
    // reset is low so the forced-low readies are visible.
    task automatic pulse_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_RegWr", {63'd0, RegWr}, 64'd0);
        check("rst_Rw", {59'd0, Rw}, 64'd0);
        check("rst_busW", {32'd0, busW}, 64'd0);
        check("rst_alu_ready", {63'd0, alu_ready}, 64'd0);
        check("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        model_prio = 1'b0;
        last_rw    = '0;
        last_busw  = '0;
        @(posedge clk);
        #1;
        check("post_rst_RegWr", {63'd0, RegWr}, 64'd0);
        $display("reset pulse -> RegWr=%0b Rw=%0d busW=%h", RegWr, Rw, busW);
    endtask

    initial begin
        #1;
        rst_n = 1'b0;
        alu_valid = 1'b1; mem_valid = 1'b1;
        #1;
        check("init_alu_ready", {63'd0, alu_ready}, 64'd0);
        check("init_mem_ready", {63'd0, mem_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("init_RegWr", {63'd0, RegWr}, 64'd0);
        check("init_Rw", {59'd0, Rw}, 64'd0);
        check("init_busW", {32'd0, busW}, 64'd0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst_n = 1'b1;
        $display("initial reset -> RegWr=%0b Rw=%0d busW=%h", RegWr, Rw, busW);

        // Single ALU request, then idle drops RegWr.
        step(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0);
        idle();

        // Continuous contention from reset: ALU, MEM, ALU, MEM.
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd1, 32'hA1A1_0000 + 32'(i), 1'b1, 5'd2, 32'hB2B2_0000 + 32'(i));
        end
        idle();

        // MEM alone three times, then contention goes to ALU.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b1, 5'd10 + 5'(i), 32'hC0DE_0000 + 32'(i));
        end
        step(1'b1, 5'd4, 32'h0000_4444, 1'b1, 5'd13, 32'hC0DE_0003);
        step(1'b1, 5'd4, 32'h0000_4444, 1'b1, 5'd13, 32'hC0DE_0003);
        idle();

        // Grant leaves prio on MEM; mid-cycle reset clears outputs and prio.
        step(1'b1, 5'd7, 32'h7777_7777, 1'b0, '0, '0);
        alu_valid = 1'b1; mem_valid = 1'b1;
        pulse_reset();
        step(1'b1, 5'd8, 32'h8888_0001, 1'b1, 5'd9, 32'h9999_0001);
        idle();

        // Register 0 write: filtered only when the zero-register option is on.
        step(1'b1, 5'd0, 32'h0000_0055, 1'b0, '0, '0);
        idle();

        // MEM alone with prio on ALU is granted at once with its data intact.
        pulse_reset();
        step(1'b0, '0, '0, 1'b1, 5'd9, 32'h1234_ABCD);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
